// File: rtl/pll_seq_pkg.sv
// Shared state encoding, counter widths and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_e;

    localparam int RETRY_W = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int timer_width(input int a, input int b, input int c);
        int w;
        w = $clog2(max3(a, b, c));
        return (w < 1) ? 1 : w;
    endfunction

    localparam int TIMER_W = timer_width(4096, 256, 16);

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indicator into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// downstream resets one by one. Define PLLSEQ_LOSS_COUNTER_EN to count loss-of-lock events.
//
// state        | meaning
// PLL_RST      | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK    | waiting for lock, retry on LOCK_TIMEOUT
// STABLE       | lock must hold LOCK_STABLE consecutive cycles
// RELEASE      | rst_n_out bits rise STAGGER cycles apart, bit 0 first
// RUN          | all domains out of reset, ready high
// FAULT        | retries exhausted, held until restart_req or reset_n
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_OUTS       = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int LOCK_STABLE    = 256,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                locked,
    input  logic                restart_req,
    output logic                pll_rst,
    output logic [NUM_OUTS-1:0] rst_n_out,
    output logic                ready,
    output logic                fault,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [7:0]          loss_cnt
);

    localparam int TW = timer_width(LOCK_TIMEOUT, LOCK_STABLE,
                                    (PLL_RST_CYCLES > STAGGER) ? PLL_RST_CYCLES : STAGGER);
    localparam logic [TW-1:0]      T_RST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]      T_TO   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]      T_STB  = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0]      T_STG  = TW'(STAGGER - 1);
    localparam logic [RETRY_W-1:0] R_MAX  = RETRY_W'(MAX_RETRIES);

    pll_state_e          state_q;
    logic [TW-1:0]       timer_q;
    logic [RETRY_W-1:0]  retry_q;
    logic                pll_rst_q;
    logic [NUM_OUTS-1:0] rst_q;
    logic [NUM_OUTS-1:0] rel_d;
    logic                ready_q;
    logic                fault_q;
    logic                locked_s;
    logic                loss_evt;

    pll_lock_sync u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (locked),
        .sync_o  (locked_s)
    );

    assign loss_evt = !locked_s && (state_q == ST_RELEASE || state_q == ST_RUN);
    assign rel_d    = (rst_q << 1) | NUM_OUTS'(1);

    always_ff @(posedge clk) begin
        if (!reset_n || restart_req) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else if (loss_evt) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (timer_q == T_RST) begin
                        state_q   <= ST_WAIT_LOCK;
                        timer_q   <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        // the cycle that detected lock already counts toward stability
                        state_q <= ST_STABLE;
                        timer_q <= TW'(1);
                    end else if (timer_q == T_TO) begin
                        timer_q   <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == R_MAX) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_PLL_RST;
                            retry_q <= retry_q + RETRY_W'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_q <= ST_WAIT_LOCK;
                        timer_q <= '0;
                    end else if (timer_q >= T_STB) begin
                        timer_q <= '0;
                        rst_q   <= NUM_OUTS'(1);
                        if (NUM_OUTS == 1) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (timer_q == T_STG) begin
                        timer_q <= '0;
                        rst_q   <= rel_d;
                        if (&rel_d) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                ST_FAULT: begin
                    pll_rst_q <= 1'b1;
                    fault_q   <= 1'b1;
                end
                default: begin
                    state_q   <= ST_PLL_RST;
                    timer_q   <= '0;
                    pll_rst_q <= 1'b1;
                    rst_q     <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLLSEQ_LOSS_COUNTER_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (!restart_req && loss_evt && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

    assign pll_rst   = pll_rst_q;
    assign rst_n_out = rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: event times predicted from a timeline model.
module tb_pll_reset_sequencer;

    localparam int N    = 4;
    localparam int PRC  = 16;
    localparam int LTO  = 4096;
    localparam int LST  = 256;
    localparam int STG  = 8;
    localparam int MAXR = 3;
    localparam int SYNC = 2;
`ifdef PLLSEQ_LOSS_COUNTER_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         locked = 1'b0;
    logic         restart_req = 1'b0;
    logic         pll_rst;
    logic [N-1:0] rst_n_out;
    logic         ready;
    logic         fault;
    logic [1:0]   retry_cnt;
    logic [7:0]   loss_cnt;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int exp_loss = 0;

    pll_reset_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .locked      (locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .rst_n_out   (rst_n_out),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Timeline model: edge numbers of events derived from the sequencing rules.
    function automatic int m_wait_entry(input int rst_entry);
        return rst_entry + PRC;
    endfunction
    function automatic int m_stable_entry(input int lock_rise, input int wait_entry);
        int a;
        a = lock_rise + SYNC + 1;
        return (a > wait_entry + 1) ? a : wait_entry + 1;
    endfunction
    function automatic int m_bit_rise(input int s, input int i);
        return s + LST - 1 + i * STG;
    endfunction
    function automatic int m_ready(input int s);
        return m_bit_rise(s, N - 1);
    endfunction
    function automatic int m_loss_edge(input int fall);
        return fall + SYNC + 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            0:       return pll_rst;
            1:       return ready;
            2:       return fault;
            default: return rst_n_out[which-3];
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int k = 0; k <= budget; k++) begin
            if (sig_val(which) === val) begin
                at = cyc;
                break;
            end
            tick(1);
        end
    endtask

    task automatic do_reset(output int r);
        reset_n = 1'b0;
        locked = 1'b0;
        restart_req = 1'b0;
        tick(3);
        reset_n = 1'b1;
        r = cyc;
        exp_loss = 0;
    endtask

    task automatic test_reset();
        int r;
        reset_n = 1'b0;
        locked = 1'b1;
        restart_req = 1'b0;
        tick(4);
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        vectors++; if (rst_n_out !== '0) begin miscompares++; $display("FAIL reset_rst_n_out: got %b want 0000", rst_n_out); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        vectors++; if (loss_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
        do_reset(r);
    endtask

    task automatic test_lock_sequence(input int delay);
        int r, e, s, at;
        do_reset(r);
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== m_wait_entry(r)) begin miscompares++; $display("FAIL seq_pll_fall: got %0d want %0d", at, m_wait_entry(r)); end
        if (r + delay > cyc) tick(r + delay - cyc);
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(r));
        for (int i = 0; i < N; i++) begin
            wait_sig(3 + i, 1'b1, 600, at);
            vectors++; if (at !== m_bit_rise(s, i)) begin miscompares++; $display("FAIL seq_bit%0d_rise: got %0d want %0d", i, at, m_bit_rise(s, i)); end
            vectors++; if (rst_n_out !== N'((1 << (i + 1)) - 1)) begin miscompares++; $display("FAIL seq_order%0d: got %b want %b", i, rst_n_out, N'((1 << (i + 1)) - 1)); end
        end
        wait_sig(1, 1'b1, 20, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL seq_ready: got %0d want %0d", at, m_ready(s)); end
        vectors++; if (retry_cnt !== 2'd0 || fault !== 1'b0 || pll_rst !== 1'b0) begin miscompares++; $display("FAIL seq_run_flags: got retry=%0d fault=%b pll_rst=%b want 0 0 0", retry_cnt, fault, pll_rst); end
    endtask

    task automatic test_timeout_fault();
        int r, w, at, q;
        do_reset(r);
        w = m_wait_entry(r);
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== w) begin miscompares++; $display("FAIL to_first_fall: got %0d want %0d", at, w); end
        for (int k = 0; k < MAXR; k++) begin
            wait_sig(0, 1'b1, LTO + 50, at);
            vectors++; if (at !== w + LTO) begin miscompares++; $display("FAIL to_retry%0d_rise: got %0d want %0d", k, at, w + LTO); end
            vectors++; if (retry_cnt !== 2'(k + 1) || fault !== 1'b0) begin miscompares++; $display("FAIL to_retry%0d_cnt: got %0d fault=%b want %0d fault=0", k, retry_cnt, fault, k + 1); end
            w = m_wait_entry(at);
            wait_sig(0, 1'b0, PRC + 5, at);
            vectors++; if (at !== w) begin miscompares++; $display("FAIL to_retry%0d_fall: got %0d want %0d", k, at, w); end
        end
        wait_sig(2, 1'b1, LTO + 50, at);
        vectors++; if (at !== w + LTO) begin miscompares++; $display("FAIL to_fault_time: got %0d want %0d", at, w + LTO); end
        vectors++; if (pll_rst !== 1'b1 || rst_n_out !== '0 || ready !== 1'b0 || retry_cnt !== 2'(MAXR)) begin miscompares++; $display("FAIL to_fault_outs: got pll_rst=%b rst=%b ready=%b retry=%0d want 1 0000 0 %0d", pll_rst, rst_n_out, ready, retry_cnt, MAXR); end
        tick(int'($urandom_range(50, 5)));
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL to_fault_hold: got %b want 1", fault); end
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        q = cyc;
        vectors++; if (fault !== 1'b0 || pll_rst !== 1'b1 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL to_restart: got fault=%b pll_rst=%b retry=%0d want 0 1 0", fault, pll_rst, retry_cnt); end
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== m_wait_entry(q)) begin miscompares++; $display("FAIL to_restart_fall: got %0d want %0d", at, m_wait_entry(q)); end
    endtask

    task automatic test_loss(input bit in_release);
        int r, e, s, at, f, d, w;
        do_reset(r);
        tick(int'($urandom_range(300, 16)));
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(r));
        if (in_release) begin
            wait_sig(3, 1'b1, 700, at);
            vectors++; if (at !== m_bit_rise(s, 0)) begin miscompares++; $display("FAIL loss_rel_bit0: got %0d want %0d", at, m_bit_rise(s, 0)); end
            tick(int'($urandom_range(20, 0)));
        end else begin
            wait_sig(1, 1'b1, 700, at);
            vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL loss_run_ready: got %0d want %0d", at, m_ready(s)); end
            tick(int'($urandom_range(30, 1)));
        end
        locked = 1'b0;
        f = cyc;
        d = int'($urandom_range(6, 3));
        if (LOSS_EN) exp_loss++;
        wait_sig(3, 1'b0, 10, at);
        vectors++; if (at !== m_loss_edge(f)) begin miscompares++; $display("FAIL loss_fall_time: got %0d want %0d", at, m_loss_edge(f)); end
        vectors++; if (rst_n_out !== '0 || ready !== 1'b0 || pll_rst !== 1'b1 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL loss_outs: got rst=%b ready=%b pll_rst=%b retry=%0d want 0000 0 1 0", rst_n_out, ready, pll_rst, retry_cnt); end
        vectors++; if (loss_cnt !== 8'(exp_loss)) begin miscompares++; $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, exp_loss); end
        if (f + d > cyc) tick(f + d - cyc);
        locked = 1'b1;
        w = m_wait_entry(m_loss_edge(f));
        wait_sig(0, 1'b0, PRC + 10, at);
        vectors++; if (at !== w) begin miscompares++; $display("FAIL loss_pll_fall: got %0d want %0d", at, w); end
        s = m_stable_entry(f + d, w);
        wait_sig(1, 1'b1, 700, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL loss_reready: got %0d want %0d", at, m_ready(s)); end
        vectors++; if (rst_n_out !== '1) begin miscompares++; $display("FAIL loss_rerun_rst: got %b want 1111", rst_n_out); end
    endtask

    task automatic test_stable_toggle();
        int r, at, p, bad, e, s;
        do_reset(r);
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== m_wait_entry(r)) begin miscompares++; $display("FAIL tog_pll_fall: got %0d want %0d", at, m_wait_entry(r)); end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            locked = (k % 2 == 0);
            p = int'($urandom_range(200, 10));
            for (int c = 0; c < p; c++) begin
                tick(1);
                if (ready !== 1'b0 || rst_n_out !== '0 || pll_rst !== 1'b0) bad++;
            end
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL tog_no_release: got %0d bad cycles want 0", bad); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL tog_retry: got %0d want 0", retry_cnt); end
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(r));
        wait_sig(1, 1'b1, 700, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL tog_final_ready: got %0d want %0d", at, m_ready(s)); end
    endtask

    task automatic test_restart_vs_loss();
        int r, e, s, at, f;
        do_reset(r);
        tick(int'($urandom_range(200, 16)));
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(r));
        wait_sig(1, 1'b1, 700, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL rvl_ready: got %0d want %0d", at, m_ready(s)); end
        tick(int'($urandom_range(20, 1)));
        locked = 1'b0;
        f = cyc;
        tick(SYNC);
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        vectors++; if (pll_rst !== 1'b1 || ready !== 1'b0 || rst_n_out !== '0 || retry_cnt !== 2'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL rvl_outs: got pll_rst=%b ready=%b rst=%b retry=%0d fault=%b want 1 0 0000 0 0", pll_rst, ready, rst_n_out, retry_cnt, fault); end
        vectors++; if (loss_cnt !== 8'(exp_loss)) begin miscompares++; $display("FAIL rvl_loss_cnt: got %0d want %0d", loss_cnt, exp_loss); end
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== m_wait_entry(m_loss_edge(f))) begin miscompares++; $display("FAIL rvl_pll_fall: got %0d want %0d", at, m_wait_entry(m_loss_edge(f))); end
        tick(5);
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(m_loss_edge(f)));
        wait_sig(1, 1'b1, 700, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL rvl_reready: got %0d want %0d", at, m_ready(s)); end
        vectors++; if (loss_cnt !== 8'(exp_loss)) begin miscompares++; $display("FAIL rvl_loss_after: got %0d want %0d", loss_cnt, exp_loss); end
    endtask

    task automatic test_reset_in_release();
        int r, e, s, at, x;
        do_reset(r);
        tick(int'($urandom_range(200, 16)));
        locked = 1'b1;
        e = cyc;
        s = m_stable_entry(e, m_wait_entry(r));
        wait_sig(4, 1'b1, 700, at);
        vectors++; if (at !== m_bit_rise(s, 1)) begin miscompares++; $display("FAIL rir_bit1: got %0d want %0d", at, m_bit_rise(s, 1)); end
        tick(int'($urandom_range(5, 0)));
        reset_n = 1'b0;
        tick(1);
        x = cyc;
        vectors++; if (pll_rst !== 1'b1 || rst_n_out !== '0 || ready !== 1'b0 || fault !== 1'b0 || retry_cnt !== 2'd0 || loss_cnt !== 8'd0) begin miscompares++; $display("FAIL rir_outs: got pll_rst=%b rst=%b ready=%b fault=%b retry=%0d loss=%0d want 1 0000 0 0 0 0", pll_rst, rst_n_out, ready, fault, retry_cnt, loss_cnt); end
        reset_n = 1'b1;
        exp_loss = 0;
        wait_sig(0, 1'b0, PRC + 5, at);
        vectors++; if (at !== m_wait_entry(x)) begin miscompares++; $display("FAIL rir_pll_fall: got %0d want %0d", at, m_wait_entry(x)); end
        s = m_stable_entry(x, m_wait_entry(x));
        wait_sig(1, 1'b1, 700, at);
        vectors++; if (at !== m_ready(s)) begin miscompares++; $display("FAIL rir_ready: got %0d want %0d", at, m_ready(s)); end
    endtask

    initial begin
        test_reset();
        test_lock_sequence(100);
        repeat (3) test_lock_sequence(int'($urandom_range(400, 16)));
        test_timeout_fault();
        test_loss(1'b0);
        test_loss(1'b1);
        test_loss(1'b0);
        test_stable_toggle();
        test_restart_vs_loss();
        test_reset_in_release();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
